// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Optional REGFILE_BYPASS_EN macro enables same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic                dup_wr_err
);

  logic [XLEN-1:0]  regs   [NREGS];
  logic [XLEN-1:0]  wr_val [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] iss_set;
  logic             dup_now;

  // Per-register write decode; later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) wr_val[r] = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) begin
        wr_hit[wr_addr[p*AW +: AW]] = 1'b1;
        wr_val[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
      end
    end
    wr_hit[0] = 1'b0;
  end

  always_comb begin
    iss_set           = '0;
    iss_set[iss_addr] = iss_en;
    iss_set[0]        = 1'b0;
  end

  // A new issue supersedes a same-cycle writeback; flush overrides everything.
  assign pend_nxt = flush ? '0 : ((pend & ~wr_hit) | iss_set);

  always_comb begin
    dup_now = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (wr_en[p] && wr_en[q] &&
            (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW]) &&
            (wr_addr[p*AW +: AW] != '0))
          dup_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      pend       <= '0;
      dup_wr_err <= 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
      end
      pend <= pend_nxt;
      if (dup_now) dup_wr_err <= 1'b1;
    end
  end

  // Register 0 never leaves its reset value and is never pending, so it reads as zero/idle.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
      rd_busy[i]              = pend[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit[rd_addr[i*AW +: AW]]) begin
        rd_data[i*XLEN +: XLEN] = wr_val[rd_addr[i*AW +: AW]];
        rd_busy[i]              = iss_set[rd_addr[i*AW +: AW]] & ~flush;
      end
`endif
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write, dual-read CPU register file.
- Configurable data width, register count, read-port count and write-port count.
- Adds a per-register pending-write scoreboard: the issue stage marks a destination busy, and writeback clears it. Decode uses the busy flags to stall.
- Sits between decode/issue (reads, issue marks) and the execute/memory writeback paths (write ports).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers. Power of two, at least 2. Register 0 is hardwired zero.
- NRD, 2, number of read ports, 1..4.
- NWR, 2, number of write ports, 1..3. A higher port index has higher priority.
- AW (localparam), $clog2(NREGS), register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  1 = the register addressed by port i has a pending write.
- wr_en  in  NWR  write enable per port.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  mark iss_addr pending.
- iss_addr  in  AW  destination register being issued.
- flush  in  1  synchronous clear of all pending bits; register data is kept.
- dup_wr_err  out  1  sticky flag: two or more enabled write ports targeted the same nonzero address in one cycle.

Behaviour:
- Reset, asynchronous:
  - All regs[1..NREGS-1] = 0.
  - All pending bits = 0.
  - dup_wr_err = 0.
  - Therefore rd_data = 0 and rd_busy = 0 on every port.
- Register 0:
  - Reads return 0 and rd_busy = 0.
  - Writes and issues targeting address 0 are ignored: no data change, no pending change, no contribution to dup_wr_err.
- Reads are combinational from registered state: zero cycles of latency relative to rd_addr.
- Writes commit on the posedge clk.
  - When multiple enabled ports target the same address, the highest-index port's data is stored.
  - dup_wr_err sets on the same edge and stays set until reset.
- Pending bit for register r, updated at posedge:
  - iss_en with iss_addr == r: set. This takes priority over a same-cycle writeback to r, because the new producer supersedes the old one.
  - Otherwise, any enabled write to r: clear.
  - flush: clears every bit, and has the highest priority over both issue and write.
- Writes to a register that is not pending are legal. Data updates and the pending bit stays 0.
- A write with no matching issue does not raise an error.
- Issuing to a register that is already pending is legal; the bit stays 1. The scoreboard tracks only the latest producer and does not count.
- Reset asserted mid-operation: all state clears immediately and asynchronously. The first edge after reset deassertion behaves normally.
- Address width: AW-bit addresses index 0..NREGS-1 exactly; no out-of-range case exists.
- Storage is flip-flops, not block RAM, as required by the single-cycle combinational read.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - If an enabled write port targets rd_addr[i] (nonzero), rd_data[i] returns that port's wr_data, using the highest-index match.
  - rd_busy[i] = 0 in the same cycle, unless iss_en also targets that address with flush low.
- Not defined:
  - Reads and busy flags reflect registered state only.
  - A write becomes visible on the cycle after the edge that commits it.

Test Plan:
- Reset, then read ports 0/1 at addresses 5 and 31 -> rd_data = 0x0000_0000, rd_busy = 0; dup_wr_err = 0.
- Write port 0 x7 = 0xDEAD_BEEF, then the next cycle read port 1 at x7 -> 0xDEAD_BEEF. Write x0 = 0xFFFF_FFFF -> reading x0 returns 0.
- Same cycle: port 0 writes x3 = 0x11 and port 1 writes x3 = 0x22 -> x3 = 0x22 and dup_wr_err = 1. It stays 1 after 10 idle cycles and clears only on reset.
- Scoreboard sequence:
  - iss x9, then read x9 -> rd_busy = 1.
  - Writeback x9 = 0x5 -> the next cycle rd_busy = 0.
  - Issue x9 with a simultaneous write to x9 -> busy stays 1 and data = the written value.
  - flush -> busy = 0.
- With REGFILE_BYPASS_EN: write x12 = 0xCAFE_0001 and read x12 in the same cycle -> rd_data = 0xCAFE_0001 in that cycle. Without the macro: rd_data = old value, then 0xCAFE_0001 on the next cycle.
- Assert reset while x4 is pending and holds 0x1234 -> immediately x4 reads 0 and rd_busy = 0, without waiting for a clock edge.
